// File: rtl/systolic_pkg.sv
// Shared definitions for the systolic array front end: feeder FSM states and
// the lane-packing helper used to slice ARRAY_SIZE*DATA_WIDTH buses.
package systolic_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    FLUSH  = 2'd2,
    DONE   = 2'd3
  } feeder_state_t;

  // Lowest bit of lane `lane` in a packed lane bus.
  function automatic int lane_lsb(input int lane, input int width);
    return lane * width;
  endfunction

endpackage

// File: rtl/systolic_skew_feeder_if.sv
// Valid/ready activation stream into the skew feeder.
interface systolic_skew_feeder_if #(
  parameter int ARRAY_SIZE = 128,
  parameter int DATA_WIDTH = 8
);

  logic                             in_valid;
  logic                             in_ready;
  logic [ARRAY_SIZE*DATA_WIDTH-1:0] in_data;

  modport master (output in_valid, output in_data, input in_ready);
  modport slave  (input in_valid, input in_data, output in_ready);

endinterface

// File: rtl/skew_delay_line.sv
// DEPTH-stage shift register carrying one lane element plus its valid flag.
module skew_delay_line #(
  parameter int DEPTH      = 1,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_vld,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_vld,
  output logic [DATA_WIDTH-1:0] out_data
);

  logic [DATA_WIDTH-1:0] stg_data_q [DEPTH];
  logic [DATA_WIDTH-1:0] stg_data_d [DEPTH];
  logic [DEPTH-1:0]      stg_vld_q;
  logic [DEPTH-1:0]      stg_vld_d;

  always_comb begin
    stg_data_d[0] = in_data;
    stg_vld_d[0]  = in_vld;
    for (int s = 1; s < DEPTH; s++) begin
      stg_data_d[s] = stg_data_q[s-1];
      stg_vld_d[s]  = stg_vld_q[s-1];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int s = 0; s < DEPTH; s++) begin
        stg_data_q[s] <= '0;
      end
      stg_vld_q <= '0;
    end else begin
      stg_data_q <= stg_data_d;
      stg_vld_q  <= stg_vld_d;
    end
  end

  assign out_data = stg_data_q[DEPTH-1];
  assign out_vld  = stg_vld_q[DEPTH-1];

endmodule

// File: rtl/systolic_skew_feeder.sv
// Skews each accepted activation vector so lane i reaches the array edge i
// cycles after lane 0, then drains the skew lines and pulses feed_done.
module systolic_skew_feeder
  import systolic_pkg::*;
#(
  parameter int ARRAY_SIZE  = 128,
  parameter int DATA_WIDTH  = 8,
  parameter int MAX_VECTORS = 1024
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 start,
  input  logic [$clog2(MAX_VECTORS+1)-1:0]     num_vectors,
  systolic_skew_feeder_if.slave                in_if,
  output logic [ARRAY_SIZE*DATA_WIDTH-1:0]     edge_data,
  output logic [ARRAY_SIZE-1:0]                edge_valid,
  output logic                                 busy,
  output logic                                 feed_done
);

  localparam int CNT_W   = $clog2(MAX_VECTORS+1);
  localparam int FLUSH_W = (ARRAY_SIZE > 1) ? $clog2(ARRAY_SIZE) : 1;

  feeder_state_t      state_q, state_d;
  logic [CNT_W-1:0]   vec_cnt_q, vec_cnt_d;
  logic [CNT_W-1:0]   num_vec_q, num_vec_d;
  logic [FLUSH_W-1:0] flush_cnt_q, flush_cnt_d;
  logic               in_ready_q, in_ready_d;
  logic               busy_q, busy_d;
  logic               feed_done_q, feed_done_d;
  logic               accept;

  // in_ready_q is high exactly while in STREAM, so it doubles as the state gate.
  assign accept = in_if.in_valid & in_ready_q;

  always_comb begin
    state_d     = state_q;
    vec_cnt_d   = vec_cnt_q;
    num_vec_d   = num_vec_q;
    flush_cnt_d = flush_cnt_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          num_vec_d = num_vectors;
          vec_cnt_d = '0;
          state_d   = (num_vectors == '0) ? DONE : STREAM;
        end
      end
      STREAM: begin
        if (accept) begin
          vec_cnt_d = vec_cnt_q + CNT_W'(1);
          if (vec_cnt_d == num_vec_q) begin
            state_d     = FLUSH;
            flush_cnt_d = '0;
          end
        end
      end
      FLUSH: begin
        if (flush_cnt_q == FLUSH_W'(ARRAY_SIZE-1)) begin
          state_d = DONE;
        end else begin
          flush_cnt_d = flush_cnt_q + FLUSH_W'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    in_ready_d  = (state_d == STREAM);
    busy_d      = (state_d != IDLE);
    feed_done_d = (state_d == DONE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      vec_cnt_q   <= '0;
      num_vec_q   <= '0;
      flush_cnt_q <= '0;
      in_ready_q  <= 1'b0;
      busy_q      <= 1'b0;
      feed_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      vec_cnt_q   <= vec_cnt_d;
      num_vec_q   <= num_vec_d;
      flush_cnt_q <= flush_cnt_d;
      in_ready_q  <= in_ready_d;
      busy_q      <= busy_d;
      feed_done_q <= feed_done_d;
    end
  end

  assign in_if.in_ready = in_ready_q;
  assign busy           = busy_q;
  assign feed_done      = feed_done_q;

  // Stage 0: accepted element or a zero bubble; lane i is i+1 stages deep.
  for (genvar i = 0; i < ARRAY_SIZE; i++) begin : g_lane
    logic [DATA_WIDTH-1:0] ld_data;
    assign ld_data = accept ? in_if.in_data[lane_lsb(i, DATA_WIDTH) +: DATA_WIDTH]
                            : '0;

    skew_delay_line #(
      .DEPTH      (i + 1),
      .DATA_WIDTH (DATA_WIDTH)
    ) u_line (
      .clk      (clk),
      .reset    (reset),
      .in_vld   (accept),
      .in_data  (ld_data),
      .out_vld  (edge_valid[i]),
      .out_data (edge_data[lane_lsb(i, DATA_WIDTH) +: DATA_WIDTH])
    );
  end

endmodule

// File: tb/tb_systolic_skew_feeder.sv
// Directed bench for systolic_skew_feeder: per-lane scoreboard of expected
// (cycle, data) pairs checked every cycle, plus FSM handshake/done checks.
module tb_systolic_skew_feeder;

  localparam int AS   = 4;
  localparam int DW   = 8;
  localparam int MAXV = 16;
  localparam int NW   = $clog2(MAXV+1);

  typedef struct packed {
    int          cyc;
    logic [DW-1:0] d;
  } exp_t;

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic [NW-1:0]    num_vectors;
  logic [AS*DW-1:0] edge_data;
  logic [AS-1:0]    edge_valid;
  logic             busy;
  logic             feed_done;

  systolic_skew_feeder_if #(.ARRAY_SIZE(AS), .DATA_WIDTH(DW)) s_if ();

  systolic_skew_feeder #(
    .ARRAY_SIZE  (AS),
    .DATA_WIDTH  (DW),
    .MAX_VECTORS (MAXV)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .num_vectors (num_vectors),
    .in_if       (s_if.slave),
    .edge_data   (edge_data),
    .edge_valid  (edge_valid),
    .busy        (busy),
    .feed_done   (feed_done)
  );

  always #5 clk = ~clk;

  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  int   exp_done = -100;
  exp_t lane_q [AS][$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one cycle and check every edge lane and feed_done for it.
  task automatic tick();
    logic exp_v;
    exp_t e;
    @(posedge clk);
    #1;
    cyc++;
    chk($sformatf("feed_done@%0d", cyc), 32'(feed_done), 32'(cyc == exp_done));
    for (int i = 0; i < AS; i++) begin
      exp_v = (lane_q[i].size() > 0) && (lane_q[i][0].cyc == cyc);
      chk($sformatf("edge_valid[%0d]@%0d", i, cyc), 32'(edge_valid[i]), 32'(exp_v));
      if (exp_v) begin
        e = lane_q[i].pop_front();
        chk($sformatf("edge_data[%0d]@%0d", i, cyc), 32'(edge_data[i*DW +: DW]), 32'(e.d));
      end else begin
        chk($sformatf("edge_zero[%0d]@%0d", i, cyc), 32'(edge_data[i*DW +: DW]), 32'd0);
      end
    end
  endtask

  task automatic do_start(input int n);
    chk("busy_before_start", 32'(busy), 32'd0);
    chk("num_vectors_in_contract", 32'(n <= MAXV), 32'd1);
    num_vectors = NW'(n);
    start       = 1'b1;
    if (n == 0) exp_done = cyc + 1;
    tick();
    start       = 1'b0;
    num_vectors = NW'($urandom_range(MAXV, 0));
    chk("busy_after_start", 32'(busy), 32'd1);
    chk("in_ready_after_start", 32'(s_if.in_ready), 32'(n != 0));
  endtask

  task automatic send(input logic [AS*DW-1:0] data, input bit last);
    exp_t e;
    chk($sformatf("in_ready_send@%0d", cyc), 32'(s_if.in_ready), 32'd1);
    for (int i = 0; i < AS; i++) begin
      e.cyc = cyc + 1 + i;
      e.d   = data[i*DW +: DW];
      lane_q[i].push_back(e);
    end
    if (last) exp_done = cyc + AS + 1;
    s_if.in_valid = 1'b1;
    s_if.in_data  = data;
    tick();
    s_if.in_valid = 1'b0;
    s_if.in_data  = $urandom;
  endtask

  task automatic bubble();
    chk($sformatf("in_ready_bubble@%0d", cyc), 32'(s_if.in_ready), 32'd1);
    s_if.in_valid = 1'b0;
    tick();
  endtask

  task automatic finish_pass();
    int budget = 0;
    chk("in_ready_after_last", 32'(s_if.in_ready), 32'd0);
    while (cyc <= exp_done && budget < 40) begin
      tick();
      budget++;
    end
    chk("pass_within_budget", 32'(cyc), 32'(exp_done + 1));
    chk("busy_after_done", 32'(busy), 32'd0);
    chk("in_ready_after_done", 32'(s_if.in_ready), 32'd0);
    for (int i = 0; i < AS; i++) begin
      chk($sformatf("scoreboard_empty[%0d]", i), 32'(lane_q[i].size()), 32'd0);
    end
  endtask

  initial begin
    reset         = 1'b1;
    start         = 1'b0;
    num_vectors   = '0;
    s_if.in_valid = 1'b0;
    s_if.in_data  = '0;

    tick();
    tick();
    chk("reset_in_ready", 32'(s_if.in_ready), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    reset = 1'b0;
    for (int k = 0; k < 5; k++) tick();
    chk("idle_in_ready", 32'(s_if.in_ready), 32'd0);
    chk("idle_busy", 32'(busy), 32'd0);

    // Back-to-back pass of three vectors.
    do_start(3);
    send(32'h04030201, 1'b0);
    send(32'h08070605, 1'b0);
    send(32'h0C0B0A09, 1'b1);
    finish_pass();
    tick();

    // Same pass with two bubbles after the first vector.
    do_start(3);
    send(32'h04030201, 1'b0);
    bubble();
    bubble();
    send(32'h08070605, 1'b0);
    send(32'h0C0B0A09, 1'b1);
    finish_pass();

    // Empty pass.
    do_start(0);
    finish_pass();
    tick();

    // start pulsed in STREAM and in FLUSH must be ignored.
    do_start(3);
    send(32'hA3A2A1A0, 1'b0);
    start       = 1'b1;
    num_vectors = NW'(1);
    send(32'hB3B2B1B0, 1'b0);
    start       = 1'b0;
    send(32'hC3C2C1C0, 1'b1);
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    finish_pass();
    tick();
    tick();
    chk("no_restart_busy", 32'(busy), 32'd0);

    // Reset asserted mid-FLUSH clears everything at once.
    do_start(2);
    send(32'h11223344, 1'b0);
    send(32'h55667788, 1'b1);
    tick();
    reset = 1'b1;
    #1;
    chk("async_rst_edge_valid", 32'(edge_valid), 32'd0);
    chk("async_rst_edge_data", edge_data, 32'd0);
    chk("async_rst_busy", 32'(busy), 32'd0);
    chk("async_rst_feed_done", 32'(feed_done), 32'd0);
    chk("async_rst_in_ready", 32'(s_if.in_ready), 32'd0);
    for (int i = 0; i < AS; i++) lane_q[i].delete();
    exp_done = -100;
    tick();
    reset = 1'b0;
    for (int k = 0; k < 4; k++) tick();
    chk("post_reset_busy", 32'(busy), 32'd0);

    // Normal single-vector pass after reset.
    do_start(1);
    send(32'hDEADBEEF, 1'b1);
    finish_pass();
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
